wbs_ctrl: RTL and testbench

WBS_CTRL -- requirements
Module: wbs_ctrl

---
 rtl/wbs_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_wbs_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_ctrl.sv
// wbs_ctrl -- Wishbone slave front end for the query-patch, leaf, best-array
// and node memories, plus the MODE/DEBUG control bits.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   wbs_*_i / wbs_ack_o/dat_o     Wishbone slave request and response
//   wbs_mode, wbs_debug           control register bits
//   wbs_qp_mem_*                  query-patch SRAM port 0 (active-low csb/web)
//   wbs_leaf_mem_*                per-leaf SRAM port 0 (one csb/web bit per leaf)
//   wbs_node_mem_*                node memory (web is an active-high write strobe)
//   wbs_best_arr_*                best-array SRAM read port 1 (active-low csb)
//
// Every request walks IDLE -> [MEM -> [WAIT]] -> ACK -> IDLE. MEM is the single
// cycle in which a memory select is asserted; WAIT is the cycle in which the
// SRAM read data becomes valid and is registered into wbs_dat_o.
module wbs_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int LEAF_SIZE  = 8,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int K          = 4,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int QADDRW     = $clog2(NUM_QUERYS),
  parameter int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_dat_i,
  input  logic [31:0]                      wbs_adr_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o,
  output logic                             wbs_mode,
  output logic                             wbs_debug,
  output logic                             wbs_qp_mem_csb0,
  output logic                             wbs_qp_mem_web0,
  output logic [QADDRW-1:0]                wbs_qp_mem_addr0,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_wpatch0,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_rpatch0,
  output logic [LEAF_SIZE-1:0]             wbs_leaf_mem_csb0,
  output logic [LEAF_SIZE-1:0]             wbs_leaf_mem_web0,
  output logic [LEAF_ADDRW-1:0]            wbs_leaf_mem_addr0,
  output logic [63:0]                      wbs_leaf_mem_wleaf0,
  input  logic [63:0]                      wbs_leaf_mem_rleaf0 [LEAF_SIZE],
  output logic                             wbs_node_mem_web,
  output logic [31:0]                      wbs_node_mem_addr,
  output logic [31:0]                      wbs_node_mem_wdata,
  input  logic [31:0]                      wbs_node_mem_rdata,
  output logic                             wbs_best_arr_csb1,
  output logic [7:0]                       wbs_best_arr_addr1,
  input  logic [63:0]                      wbs_best_arr_rdata1
);

  localparam int PW    = PATCH_SIZE * DATA_WIDTH;
  localparam int UPW   = PW - 32;
  localparam int LIDXW = $clog2(LEAF_SIZE);

  localparam logic [31:0] ADR_MODE    = 32'h3000_0000;
  localparam logic [31:0] ADR_DEBUG   = 32'h3000_0004;
  localparam logic [31:0] ADR_DONE    = 32'h3000_0008;
  localparam logic [31:0] REGION_CTRL = 32'h3000_0000;
  localparam logic [31:0] REGION_QRY  = 32'h3001_0000;
  localparam logic [31:0] REGION_LEAF = 32'h3002_0000;
  localparam logic [31:0] REGION_BEST = 32'h3003_0000;
  localparam logic [31:0] REGION_NODE = 32'h3004_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WAIT, ST_ACK} state_t;
  typedef enum logic [2:0] {
    KIND_NONE, KIND_MODE, KIND_DEBUG, KIND_DONE,
    KIND_QUERY, KIND_LEAF, KIND_BEST, KIND_NODE
  } kind_t;

  state_t            state, state_next;
  kind_t             dec_kind, req_kind;
  logic              req_we, req_half;
  logic [LIDXW-1:0]  req_leaf;
  logic [31:0]       hold;
  logic [31:0]       rd_sel;
  logic              accept, needs_mem;
  logic [31:0]       region;
  logic              unused_ok;

  // Byte selects and K are not used by this controller.
  assign unused_ok = ^{wbs_sel_i, 32'(K)};

  assign region = wbs_adr_i & 32'hFFFF_0000;
  assign accept = wbs_cyc_i & wbs_stb_i;

  always_comb begin
    dec_kind = KIND_NONE;
    case (region)
      REGION_CTRL: begin
        if (wbs_adr_i == ADR_MODE)       dec_kind = KIND_MODE;
        else if (wbs_adr_i == ADR_DEBUG) dec_kind = KIND_DEBUG;
        else if (wbs_adr_i == ADR_DONE)  dec_kind = KIND_DONE;
      end
      REGION_QRY:  dec_kind = KIND_QUERY;
      REGION_LEAF: dec_kind = KIND_LEAF;
      REGION_BEST: dec_kind = KIND_BEST;
      REGION_NODE: dec_kind = KIND_NODE;
      default:     dec_kind = KIND_NONE;
    endcase
  end

  // Only patch/leaf upper-half writes, memory reads and node accesses touch a
  // memory; everything else (including a BEST write) acks straight away.
  always_comb begin
    needs_mem = 1'b0;
    case (dec_kind)
      KIND_QUERY, KIND_LEAF: needs_mem = wbs_we_i ? wbs_adr_i[2] : 1'b1;
      KIND_BEST:             needs_mem = ~wbs_we_i;
      KIND_NODE:             needs_mem = 1'b1;
      default:               needs_mem = 1'b0;
    endcase
  end

  // Addresses and write data follow the live bus; a Wishbone master holds
  // them stable until it sees ack, so they are valid throughout MEM.
  assign wbs_qp_mem_addr0    = wbs_adr_i[3 +: QADDRW];
  assign wbs_qp_mem_wpatch0  = {wbs_dat_i[UPW-1:0], hold};
  assign wbs_leaf_mem_addr0  = wbs_adr_i[6 +: LEAF_ADDRW];
  assign wbs_leaf_mem_wleaf0 = {wbs_dat_i, hold};
  assign wbs_best_arr_addr1  = wbs_adr_i[10:3];
  assign wbs_node_mem_addr   = wbs_adr_i;
  assign wbs_node_mem_wdata  = wbs_dat_i;
  assign wbs_ack_o           = (state == ST_ACK);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next         = state;
    wbs_qp_mem_csb0    = 1'b1;
    wbs_qp_mem_web0    = 1'b1;
    wbs_leaf_mem_csb0  = '1;
    wbs_leaf_mem_web0  = '1;
    wbs_node_mem_web   = 1'b0;
    wbs_best_arr_csb1  = 1'b1;
    case (state)
      ST_IDLE: if (accept) state_next = needs_mem ? ST_MEM : ST_ACK;
      ST_MEM: begin
        state_next = req_we ? ST_ACK : ST_WAIT;
        case (req_kind)
          KIND_QUERY: begin
            wbs_qp_mem_csb0 = 1'b0;
            wbs_qp_mem_web0 = ~req_we;
          end
          KIND_LEAF: begin
            wbs_leaf_mem_csb0[req_leaf] = 1'b0;
            wbs_leaf_mem_web0[req_leaf] = ~req_we;
          end
          KIND_BEST: wbs_best_arr_csb1 = 1'b0;
          KIND_NODE: wbs_node_mem_web  = req_we;
          default: ;
        endcase
      end
      ST_WAIT: state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The upper half of a query patch is narrower than 32 bits and is
  // zero-extended on readback.
  always_comb begin
    rd_sel = '0;
    case (req_kind)
      KIND_QUERY: rd_sel = req_half ? 32'(wbs_qp_mem_rpatch0[PW-1:32])
                                    : wbs_qp_mem_rpatch0[31:0];
      KIND_LEAF:  rd_sel = req_half ? wbs_leaf_mem_rleaf0[req_leaf][63:32]
                                    : wbs_leaf_mem_rleaf0[req_leaf][31:0];
      KIND_BEST:  rd_sel = req_half ? wbs_best_arr_rdata1[63:32]
                                    : wbs_best_arr_rdata1[31:0];
      KIND_NODE:  rd_sel = wbs_node_mem_rdata;
      default:    rd_sel = '0;
    endcase
  end

  // Register side effects and immediate read data happen on the accepting
  // edge; memory read data is registered at the end of WAIT. wbs_dat_o is
  // only ever written by reads so it keeps its last value otherwise.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_kind  <= KIND_NONE;
      req_we    <= 1'b0;
      req_half  <= 1'b0;
      req_leaf  <= '0;
      hold      <= '0;
      wbs_mode  <= 1'b0;
      wbs_debug <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      if (state == ST_IDLE && accept) begin
        req_kind <= dec_kind;
        req_we   <= wbs_we_i;
        req_half <= wbs_adr_i[2];
        req_leaf <= wbs_adr_i[3 +: LIDXW];
        if (wbs_we_i) begin
          case (dec_kind)
            KIND_MODE:             wbs_mode  <= wbs_dat_i[0];
            KIND_DEBUG:            wbs_debug <= wbs_dat_i[0];
            KIND_QUERY, KIND_LEAF: if (!wbs_adr_i[2]) hold <= wbs_dat_i;
            default: ;
          endcase
        end else begin
          case (dec_kind)
            KIND_MODE:            wbs_dat_o <= {31'b0, wbs_mode};
            KIND_DEBUG:           wbs_dat_o <= {31'b0, wbs_debug};
            KIND_DONE, KIND_NONE: wbs_dat_o <= '0;
            default: ;
          endcase
        end
      end
      if (state == ST_WAIT) wbs_dat_o <= rd_sel;
    end
  end

endmodule

// File: tb/tb_wbs_ctrl.sv
// tb_wbs_ctrl -- directed bench for wbs_ctrl. Reads push their expected data
// into a scoreboard queue; a monitor pops and compares whenever a read ack
// appears. Memory strobes are recorded by a second monitor and checked after
// each transaction.
module tb_wbs_ctrl;

  localparam int PW = 55;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbs_mode, wbs_debug;
  logic        qp_csb0, qp_web0;
  logic [8:0]  qp_addr0;
  logic [PW-1:0] qp_wpatch0, qp_rpatch0 = '0;
  logic [7:0]  leaf_csb0, leaf_web0;
  logic [5:0]  leaf_addr0;
  logic [63:0] leaf_wleaf0;
  logic [63:0] leaf_rleaf0 [8];
  logic        node_web;
  logic [31:0] node_addr, node_wdata, node_rdata = '0;
  logic        best_csb1;
  logic [7:0]  best_addr1;
  logic [63:0] best_rdata1 = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  int          qp_sel_cnt = 0, leaf_sel_cnt = 0, best_sel_cnt = 0, node_web_cnt = 0;
  logic [8:0]  qp_last_addr;
  logic        qp_last_web;
  logic [PW-1:0] qp_last_wpatch;
  logic [7:0]  leaf_last_csb, leaf_last_web;
  logic [63:0] leaf_last_wleaf;
  logic [7:0]  best_last_addr;
  logic [31:0] node_last_addr, node_last_wdata;

  wbs_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .wbs_mode(wbs_mode), .wbs_debug(wbs_debug),
    .wbs_qp_mem_csb0(qp_csb0), .wbs_qp_mem_web0(qp_web0),
    .wbs_qp_mem_addr0(qp_addr0), .wbs_qp_mem_wpatch0(qp_wpatch0),
    .wbs_qp_mem_rpatch0(qp_rpatch0),
    .wbs_leaf_mem_csb0(leaf_csb0), .wbs_leaf_mem_web0(leaf_web0),
    .wbs_leaf_mem_addr0(leaf_addr0), .wbs_leaf_mem_wleaf0(leaf_wleaf0),
    .wbs_leaf_mem_rleaf0(leaf_rleaf0),
    .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
    .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata),
    .wbs_best_arr_csb1(best_csb1), .wbs_best_arr_addr1(best_addr1),
    .wbs_best_arr_rdata1(best_rdata1)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor: 1 time unit after each rising edge, a read ack must
  // match the oldest queued expectation.
  always @(posedge wb_clk_i) begin
    #1;
    if (wbs_ack_o && wbs_cyc_i && !wbs_we_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_read_ack", 64'(wbs_dat_o), 64'hDEAD_0000_0000_0000);
      end else begin
        checkOutput(name_q.pop_front(), 64'(wbs_dat_o), 64'(exp_q.pop_front()));
      end
    end
  end

  // Strobe recorder: samples memory selects mid-cycle.
  always @(negedge wb_clk_i) begin
    if (!qp_csb0) begin
      qp_sel_cnt++;
      qp_last_addr   = qp_addr0;
      qp_last_web    = qp_web0;
      qp_last_wpatch = qp_wpatch0;
    end
    if (leaf_csb0 != 8'hFF) begin
      leaf_sel_cnt++;
      leaf_last_csb   = leaf_csb0;
      leaf_last_web   = leaf_web0;
      leaf_last_wleaf = leaf_wleaf0;
    end
    if (!best_csb1) begin
      best_sel_cnt++;
      best_last_addr = best_addr1;
    end
    if (node_web) begin
      node_web_cnt++;
      node_last_addr  = node_addr;
      node_last_wdata = node_wdata;
    end
  end

  // One Wishbone transaction; reads queue their expected data first.
  task automatic applyStimulus(input logic [31:0] adr, input logic we,
                               input logic [31:0] dat, input logic [31:0] exp,
                               input string name);
    bit got = 0;
    @(negedge wb_clk_i);
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_we_i  = we;
    if (!we) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1;
    end
    if (!got) begin
      checkOutput({name, "_ack_timeout"}, 64'd0, 64'd1);
      if (!we) begin
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    checkOutput({name, "_ack_single"}, 64'(wbs_ack_o), 64'd0);
  endtask

  initial begin
    int s_qp, s_leaf, s_best, s_node;
    bit ack_seen;
    for (int i = 0; i < 8; i++) leaf_rleaf0[i] = 64'h0;

    $display("[TB] reset");
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    checkOutput("rst_ack", 64'(wbs_ack_o), 64'd0);
    checkOutput("rst_dat", 64'(wbs_dat_o), 64'd0);
    checkOutput("rst_mode", 64'(wbs_mode), 64'd0);
    checkOutput("rst_debug", 64'(wbs_debug), 64'd0);
    checkOutput("rst_qp_csb_web", 64'({qp_csb0, qp_web0}), 64'h3);
    checkOutput("rst_leaf_csb", 64'(leaf_csb0), 64'hFF);
    checkOutput("rst_leaf_web", 64'(leaf_web0), 64'hFF);
    checkOutput("rst_node_web", 64'(node_web), 64'd0);
    checkOutput("rst_best_csb", 64'(best_csb1), 64'd1);
    wb_rst_i = 1'b0;

    $display("[TB] control registers");
    applyStimulus(32'h3000_0004, 1'b1, 32'h1, 32'h0, "wr_debug1");
    checkOutput("debug_set", 64'(wbs_debug), 64'd1);
    applyStimulus(32'h3000_0000, 1'b1, 32'h1, 32'h0, "wr_mode1");
    checkOutput("mode_set", 64'(wbs_mode), 64'd1);
    applyStimulus(32'h3000_0004, 1'b1, 32'hFFFF_FFFE, 32'h0, "wr_debug0");
    checkOutput("debug_clr", 64'(wbs_debug), 64'd0);
    checkOutput("mode_kept", 64'(wbs_mode), 64'd1);
    applyStimulus(32'h3000_0000, 1'b0, 32'h0, 32'h1, "rd_mode");
    applyStimulus(32'h3000_0004, 1'b0, 32'h0, 32'h0, "rd_debug");
    applyStimulus(32'h3000_0008, 1'b1, 32'h1, 32'h0, "wr_done");
    applyStimulus(32'h3000_0008, 1'b0, 32'h0, 32'h0, "rd_done");
    checkOutput("regs_after_done", 64'({wbs_mode, wbs_debug}), 64'h2);

    $display("[TB] query patch memory");
    qp_rpatch0 = 55'h00_1010_DEAD_BEEF;
    s_qp = qp_sel_cnt;
    applyStimulus(32'h3001_0008, 1'b0, 32'h0, 32'hDEAD_BEEF, "rd_qp_lo");
    checkOutput("qp_rd_sel_once", 64'(qp_sel_cnt - s_qp), 64'd1);
    checkOutput("qp_rd_addr", 64'(qp_last_addr), 64'd1);
    checkOutput("qp_rd_web", 64'(qp_last_web), 64'd1);
    applyStimulus(32'h3001_000C, 1'b0, 32'h0, 32'h0000_1010, "rd_qp_hi");
    s_qp = qp_sel_cnt;
    applyStimulus(32'h3001_0010, 1'b1, 32'h0123_4567, 32'h0, "wr_qp_lo");
    checkOutput("qp_lo_no_access", 64'(qp_sel_cnt - s_qp), 64'd0);
    applyStimulus(32'h3001_0014, 1'b1, 32'h000B_CDEF, 32'h0, "wr_qp_hi");
    checkOutput("qp_wr_sel_once", 64'(qp_sel_cnt - s_qp), 64'd1);
    checkOutput("qp_wr_web", 64'(qp_last_web), 64'd0);
    checkOutput("qp_wr_addr", 64'(qp_last_addr), 64'd2);
    checkOutput("qp_wpatch", 64'(qp_last_wpatch), 64'h0B_CDEF_0123_4567);

    $display("[TB] leaf memories");
    leaf_rleaf0[7] = 64'h1100_1010_DEAD_BEEF;
    s_leaf = leaf_sel_cnt;
    applyStimulus(32'h3002_0038, 1'b0, 32'h0, 32'hDEAD_BEEF, "rd_leaf_lo");
    checkOutput("leaf_rd_csb", 64'(leaf_last_csb), 64'h7F);
    checkOutput("leaf_rd_web", 64'(leaf_last_web), 64'hFF);
    applyStimulus(32'h3002_003C, 1'b0, 32'h0, 32'h1100_1010, "rd_leaf_hi");
    checkOutput("leaf_rd_sel_twice", 64'(leaf_sel_cnt - s_leaf), 64'd2);
    s_leaf = leaf_sel_cnt;
    applyStimulus(32'h3002_0018, 1'b1, 32'h7654_3210, 32'h0, "wr_leaf_lo");
    applyStimulus(32'h3002_001C, 1'b1, 32'hFEDC_BA98, 32'h0, "wr_leaf_hi");
    checkOutput("leaf_wr_sel_once", 64'(leaf_sel_cnt - s_leaf), 64'd1);
    checkOutput("leaf_wr_csb", 64'(leaf_last_csb), 64'hF7);
    checkOutput("leaf_wr_web", 64'(leaf_last_web), 64'hF7);
    checkOutput("leaf_wleaf", leaf_last_wleaf, 64'hFEDC_BA98_7654_3210);

    $display("[TB] best array");
    best_rdata1 = 64'h1100_1010_DEAD_BEEF;
    s_best = best_sel_cnt;
    applyStimulus(32'h3003_0038, 1'b0, 32'h0, 32'hDEAD_BEEF, "rd_best_lo");
    checkOutput("best_addr", 64'(best_last_addr), 64'd7);
    applyStimulus(32'h3003_003C, 1'b0, 32'h0, 32'h1100_1010, "rd_best_hi");
    checkOutput("best_sel_twice", 64'(best_sel_cnt - s_best), 64'd2);

    $display("[TB] unmapped");
    applyStimulus(32'h3005_0000, 1'b0, 32'h0, 32'h0, "rd_unmapped");
    s_qp = qp_sel_cnt; s_leaf = leaf_sel_cnt; s_node = node_web_cnt;
    applyStimulus(32'h3000_000C, 1'b1, 32'hFFFF_FFFF, 32'h0, "wr_unmapped");
    checkOutput("unmapped_no_side", 64'({qp_sel_cnt - s_qp, leaf_sel_cnt - s_leaf, node_web_cnt - s_node}), 64'd0);
    checkOutput("unmapped_regs", 64'({wbs_mode, wbs_debug}), 64'h2);

    $display("[TB] node memory");
    node_rdata = 32'hCAFE_F00D;
    s_node = node_web_cnt;
    applyStimulus(32'h3004_0001, 1'b1, 32'h0001_B801, 32'h0, "wr_node");
    checkOutput("node_web_once", 64'(node_web_cnt - s_node), 64'd1);
    checkOutput("node_wr_addr", 64'(node_last_addr), 64'h3004_0001);
    checkOutput("node_wr_data", 64'(node_last_wdata), 64'h0001_B801);
    checkOutput("dat_o_holds", 64'(wbs_dat_o), 64'd0);
    applyStimulus(32'h3004_0001, 1'b0, 32'h0, 32'hCAFE_F00D, "rd_node");
    applyStimulus(32'h3000_0004, 1'b1, 32'h1, 32'h0, "wr_debug1b");

    $display("[TB] reset during node read");
    @(negedge wb_clk_i);
    wbs_adr_i = 32'h3004_0001;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    checkOutput("abort_ack", 64'(wbs_ack_o), 64'd0);
    checkOutput("abort_dat", 64'(wbs_dat_o), 64'd0);
    checkOutput("abort_regs", 64'({wbs_mode, wbs_debug}), 64'd0);
    checkOutput("abort_node_web", 64'(node_web), 64'd0);
    checkOutput("abort_best_csb", 64'(best_csb1), 64'd1);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    ack_seen = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) ack_seen = 1;
    end
    checkOutput("abort_no_ack", 64'(ack_seen), 64'd0);

    s_qp = qp_sel_cnt;
    applyStimulus(32'h3001_0014, 1'b1, 32'h0001_2345, 32'h0, "wr_qp_hi_after_rst");
    checkOutput("hold_cleared", 64'(qp_last_wpatch), 64'h01_2345_0000_0000);
    checkOutput("qp_sel_after_rst", 64'(qp_sel_cnt - s_qp), 64'd1);

    repeat (2) @(negedge wb_clk_i);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
